// File: rtl/fetch_queue_if.sv
// fetch_queue_if: PC, instruction-memory and decode-side signals of the fetch stage.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_in;
  logic            pc_advance;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc_plus_4;
  modport master (
    input  pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, id_ready,
    output pc_advance, imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_pc_plus_4
  );
  modport slave (
    output pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, id_ready,
    input  pc_advance, imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_pc_plus_4
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch with PC tagging, credit-limited issue and flush draining.
// Defining FETCH_PERF_CNT_EN adds perf_stall_cnt (cycles decode is starved while running).
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input logic clk,
  input logic reset,
  fetch_queue_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [XLEN-1:0] fifo_instr [DEPTH];
  logic [XLEN-1:0] tag_q      [DEPTH];
  logic [PW-1:0]   fifo_rd, fifo_wr, tag_rd, tag_wr;
  logic [CW-1:0]   fifo_cnt, outstanding, drop_cnt, inflight, drop_nxt;
  logic            credit, req, accept, rsp, keep, pop, id_valid;
  // Responses still owed by memory: live ones plus those already condemned by a flush.
  assign inflight = outstanding + drop_cnt;
  assign credit   = (outstanding + fifo_cnt) < CW'(DEPTH);
  assign rsp      = bus.imem_rsp_valid && inflight != '0;
  assign keep     = rsp && drop_cnt == '0 && !bus.flush;
  assign pop      = id_valid && bus.id_ready;
  assign drop_nxt = bus.flush ? inflight - CW'(rsp) : drop_cnt - CW'(rsp && drop_cnt != '0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= RUN;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == RUN) ? ((bus.flush && drop_nxt != '0) ? DRAIN : RUN)
                               : ((drop_nxt == '0) ? RUN : DRAIN);
  always_comb begin
    id_valid           = fifo_cnt != '0;
    req                = reset && state == RUN && credit && !bus.flush;
    accept             = req && bus.imem_req_ready;
    bus.imem_req_valid = req;
    bus.pc_advance     = accept;
    bus.imem_req_addr  = bus.pc_in;
    bus.id_valid       = id_valid;
    bus.id_pc          = id_valid ? fifo_pc[fifo_rd] : '0;
    bus.id_instr       = id_valid ? fifo_instr[fifo_rd] : '0;
    bus.id_pc_plus_4   = id_valid ? fifo_pc[fifo_rd] + XLEN'(4) : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      fifo_cnt    <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (bus.flush) begin
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      fifo_cnt    <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      outstanding <= '0;
      drop_cnt    <= drop_nxt;
    end else begin
      fifo_rd     <= fifo_rd + PW'(pop);
      fifo_wr     <= fifo_wr + PW'(keep);
      fifo_cnt    <= fifo_cnt + CW'(keep) - CW'(pop);
      tag_rd      <= tag_rd + PW'(keep);
      tag_wr      <= tag_wr + PW'(accept);
      outstanding <= outstanding + CW'(accept) - CW'(keep);
      drop_cnt    <= drop_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (keep) begin
      fifo_pc[fifo_wr]    <= tag_q[tag_rd];
      fifo_instr[fifo_wr] <= bus.imem_rsp_data;
    end
    if (accept) tag_q[tag_wr] <= bus.pc_in;
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) perf_stall_cnt <= '0;
    else if (state == RUN && bus.id_ready && !id_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed fetch_queue tests, outputs compared every cycle against a queue-level model.
module tb_fetch_queue;
  localparam int DEPTH = 2;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  typedef struct {int due; logic [31:0] a;} req_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  fetch_queue_if #(.XLEN(32)) bus ();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif
  fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int drop = 0;
  logic hold = 1'b0;
  logic [31:0] target = 32'h0;
  logic [31:0] m_perf = 32'h0;
  ent_t fq[$];
  logic [31:0] tq[$];
  req_t mq[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'd3 + 32'h13;
  endfunction

  function automatic logic e_req();
    return reset && drop == 0 && (tq.size() + fq.size() < DEPTH) && !bus.flush;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    logic v, hv;
    v  = e_req();
    hv = reset && fq.size() > 0;
    chk("req_valid", 32'(bus.imem_req_valid), 32'(v));
    chk("pc_advance", 32'(bus.pc_advance), 32'(v && bus.imem_req_ready));
    chk("req_addr", bus.imem_req_addr, bus.pc_in);
    chk("id_valid", 32'(bus.id_valid), 32'(hv));
    chk("id_pc", bus.id_pc, hv ? fq[0].pc : 32'h0);
    chk("id_instr", bus.id_instr, hv ? fq[0].ins : 32'h0);
    chk("id_pc_plus_4", bus.id_pc_plus_4, hv ? fq[0].pc + 32'd4 : 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall_cnt", perf_stall_cnt, reset ? m_perf : 32'h0);
`endif
  end

  task automatic step();
    logic adv, rsp, acc, pop, fl, rs, stall;
    logic [31:0] d;
    ent_t e;
    req_t r;
    int n;
    @(negedge clk);
    #1;
    rs    = reset;
    adv   = bus.pc_advance;
    acc   = e_req() && bus.imem_req_ready;
    rsp   = bus.imem_rsp_valid;
    d     = bus.imem_rsp_data;
    pop   = fq.size() > 0 && bus.id_ready;
    fl    = bus.flush;
    stall = drop == 0 && bus.id_ready && fq.size() == 0;
    @(posedge clk);
    #1;
    if (!rs) begin
      fq.delete();
      tq.delete();
      mq.delete();
      drop   = 0;
      m_perf = 32'h0;
    end else begin
      if (stall) m_perf++;
      if (fl) begin
        n = tq.size() + drop;
        if (rsp && n > 0) n--;
        drop = n;
        tq.delete();
        fq.delete();
      end else begin
        if (pop) void'(fq.pop_front());
        if (rsp) begin
          if (drop > 0) drop--;
          else if (tq.size() > 0) begin
            e.pc  = tq.pop_front();
            e.ins = d;
            fq.push_back(e);
          end
        end
        if (acc) tq.push_back(bus.pc_in);
      end
      if (rsp && mq.size() > 0) void'(mq.pop_front());
      if (adv) begin
        r.due = cyc + lat;
        r.a   = bus.pc_in;
        mq.push_back(r);
      end
    end
    if (fl) bus.pc_in = target;
    else if (adv) bus.pc_in = bus.pc_in + 32'd4;
    cyc++;
    bus.imem_rsp_valid = !hold && mq.size() > 0 && mq[0].due <= cyc;
    bus.imem_rsp_data  = bus.imem_rsp_valid ? mem(mq[0].a) : 32'h0;
  endtask

  task automatic do_reset(input logic [31:0] start);
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.pc_in = start;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic wait_id(input int budget);
    int k;
    k = 0;
    while (!bus.id_valid && k < budget) begin
      step();
      k++;
    end
    chk("wait_id", 32'(bus.id_valid), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.flush = 1'b0;
    bus.id_ready = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    bus.pc_in = 32'h0;
    step();
    step();
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_pc_advance", 32'(bus.pc_advance), 32'h0);
    chk("rst_id_valid", 32'(bus.id_valid), 32'h0);
    chk("rst_id_pc_plus_4", bus.id_pc_plus_4, 32'h0);
    reset = 1'b1;
    #1;
    chk("rel_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("rel_req_addr", bus.imem_req_addr, 32'h0);
    chk("rel_pc_advance", 32'(bus.pc_advance), 32'h1);
    // streaming, 1-cycle memory
    bus.id_ready = 1'b1;
    wait_id(8);
    chk("s0_pc", bus.id_pc, 32'h0);
    chk("s0_instr", bus.id_instr, 32'h13);
    chk("s0_p4", bus.id_pc_plus_4, 32'h4);
    step();
    wait_id(8);
    chk("s1_pc", bus.id_pc, 32'h4);
    chk("s1_instr", bus.id_instr, 32'h1F);
    chk("s1_p4", bus.id_pc_plus_4, 32'h8);
    step();
    wait_id(8);
    chk("s2_pc", bus.id_pc, 32'h8);
    chk("s2_instr", bus.id_instr, 32'h2B);
    chk("s2_p4", bus.id_pc_plus_4, 32'hC);
    // backpressure fills the queue
    bus.id_ready = 1'b0;
    do_reset(32'h0);
    repeat (6) step();
    chk("bp_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("bp_pc_advance", 32'(bus.pc_advance), 32'h0);
    chk("bp_pc_hold", bus.pc_in, 32'h8);
    chk("bp_id_valid", 32'(bus.id_valid), 32'h1);
    chk("bp_id_pc", bus.id_pc, 32'h0);
    bus.id_ready = 1'b1;
    step();
    chk("bp_next_pc", bus.id_pc, 32'h4);
    // flush with two requests in flight, latency 3
    lat = 3;
    do_reset(32'h0);
    step();
    step();
    chk("fl_credit_stall", 32'(bus.imem_req_valid), 32'h0);
    bus.flush = 1'b1;
    target = 32'h100;
    step();
    bus.flush = 1'b0;
    chk("fl_id_valid", 32'(bus.id_valid), 32'h0);
    chk("fl_drain0", 32'(bus.imem_req_valid), 32'h0);
    step();
    chk("fl_drain1", 32'(bus.imem_req_valid), 32'h0);
    step();
    chk("fl_resume", 32'(bus.imem_req_valid), 32'h1);
    chk("fl_addr", bus.imem_req_addr, 32'h100);
    wait_id(10);
    chk("fl_id_pc", bus.id_pc, 32'h100);
    chk("fl_id_instr", bus.id_instr, 32'h313);
    // PC wrap-around
    lat = 1;
    do_reset(32'hFFFF_FFFC);
    wait_id(8);
    chk("wr_pc", bus.id_pc, 32'hFFFF_FFFC);
    chk("wr_p4", bus.id_pc_plus_4, 32'h0);
    chk("wr_instr", bus.id_instr, 32'h7);
`ifdef FETCH_PERF_CNT_EN
    hold = 1'b1;
    bus.id_ready = 1'b1;
    do_reset(32'h0);
    repeat (5) step();
    chk("perf_5", perf_stall_cnt, 32'd5);
    hold = 1'b0;
`endif
    // mixed traffic: back-to-back flushes, misaligned redirects, mid-run reset
    do_reset(32'h40);
    for (int i = 0; i < 300; i++) begin
      bus.id_ready = (i % 3) != 1;
      bus.imem_req_ready = (i % 5) != 2;
      lat = 1 + (i % 3);
      bus.flush = (i % 23 == 7) || (i % 23 == 8) || (i % 31 == 4);
      target = 32'h200 + 32'(i);
      if (i == 150) reset = 1'b0;
      if (i == 152) reset = 1'b1;
      step();
    end
    bus.flush = 1'b0;
    repeat (6) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage that sits directly downstream of the PC register (`pc`).
- Consumes the current PC, issues in-order requests to instruction memory and tags each response with its PC.
- Buffers {pc, instr} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Drives `pc_advance` so the PC register steps to pc+4 only when a request is accepted, and discards in-flight work on `flush` (branch/jump redirect).

Parameters:
- DEPTH, 2, FIFO entries and maximum outstanding requests (power of 2, 2..8).
- XLEN, 32, address/instruction width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- pc_in  input  XLEN  current PC from the PC register.
- pc_advance  output  1  enable for the PC register to load pc+4 next edge.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  XLEN  fetch address (= pc_in).
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  response valid; in order, at least 1 cycle after acceptance.
- imem_rsp_data  input  XLEN  fetched instruction.
- flush  input  1  redirect; kill all queued and in-flight fetches.
- id_valid  output  1  decode entry valid.
- id_ready  input  1  decode accepts entry.
- id_pc  output  XLEN  PC of the head entry.
- id_instr  output  XLEN  instruction of the head entry.
- id_pc_plus_4  output  XLEN  id_pc + 4, wrapping modulo 2^XLEN.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; FIFO, outstanding counter, drop counter and PC-tag queue cleared; state = RUN.
- Credit rule: issue is allowed only when outstanding + fifo_count < DEPTH.
- imem_req_valid = (state==RUN) && credit && !flush. imem_req_addr = pc_in, combinational.
- pc_advance = imem_req_valid && imem_req_ready. Accept pushes pc_in into the tag queue; outstanding += 1.
- Response:
  - imem_rsp_valid with drop_cnt==0: pop tag queue, push {tag, imem_rsp_data} into FIFO; outstanding -= 1.
  - imem_rsp_valid with drop_cnt>0: discard the data; drop_cnt -= 1.
- Same-cycle accept and response: counters net to no change; FIFO never overflows because of the credit rule.
- Decode handshake:
  - id_valid = fifo not empty. id_pc, id_instr, id_pc_plus_4 come from the head entry, combinational from the FIFO registers.
  - Pop on id_valid && id_ready. Outputs are held stable while id_valid && !id_ready.
  - Push and pop in the same cycle are both allowed when full or empty-with-bypass. Bypass is not used: a response appears on id_* at the earliest 1 cycle after imem_rsp_valid.
- Flush (sampled at the clock edge):
  - FIFO emptied, tag queue cleared.
  - drop_cnt <= outstanding, less 1 if a response arrives in that same cycle.
  - outstanding <= 0.
  - id_valid is 0 the next cycle.
  - No request is issued in the flush cycle. The redirect target is loaded into the PC register by external logic in the same cycle.
- State machine:
  - RUN → DRAIN on flush when the resulting drop_cnt > 0.
  - DRAIN → RUN when drop_cnt reaches 0.
  - A flush while in DRAIN only recomputes drop_cnt; responses for the newer redirect never exist yet.
  - No requests are issued in DRAIN.
- Reset mid-operation discards everything immediately. Memory responses arriving after reset release are ignored only if the integrator also resets memory; fetch_queue treats any rsp with outstanding==0 and drop_cnt==0 as an error and drops it.
- Misaligned pc_in (bits [1:0] != 0) is forwarded unchanged; trap detection belongs to decode.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output `perf_stall_cnt` [31:0], incremented each cycle where id_ready=1 && id_valid=0 in RUN. Wraps at 2^32. Reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset sequence: hold reset=0 for 2 cycles with pc_in=0x0 → all outputs 0. After release, with imem_req_ready=1, cycle 1 shows imem_req_valid=1, imem_req_addr=0x0, pc_advance=1.
- Streaming, 1-cycle memory latency, id_ready=1, pc 0x0,0x4,0x8 → id_pc 0x0/0x4/0x8 in order, id_pc_plus_4 0x4/0x8/0xC, id_instr matches memory words.
- Backpressure: id_ready=0 with DEPTH=2 → after 2 accepts imem_req_valid=0 and pc_advance=0, pc holds at 0x8. id_* stays at 0x0 until id_ready=1.
- Flush with 2 outstanding requests (latency 3) → id_valid=0 next cycle, state DRAIN, 2 later responses dropped. The first request after the drain uses the redirect pc_in=0x100 and yields id_pc=0x100.
- Wrap-around: pc_in=0xFFFFFFFC → id_pc_plus_4=0x00000000.
- With FETCH_PERF_CNT_EN: 5 cycles of id_ready=1 while memory withholds responses → perf_stall_cnt=5.
